// File: rtl/spi_flash_responder.sv
// spi_flash_responder: byte-wide SPI flash responder with a word-addressed memory.
// Optional READ_STATUS command (8'h05) and write counter enabled by SPI_RESP_STATUS_EN.
module spi_flash_responder #(
  parameter int ADDR_W = 6,
  parameter int SYNC_N = 2
) (
  input  logic       p_clk,
  input  logic       p_reset_n,
  input  logic       s_clk,
  input  logic       s_css,
  input  logic [7:0] s_mosi,
  output logic [7:0] s_miso,
  output logic       cmd_err
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, SKIP, STAT} state_t;
  state_t state;
  logic [SYNC_N-1:0][9:0] sync_q;
  logic clk_s, css_s, clk_d, strobe;
  logic [7:0] mosi_s;
  logic [1:0] cnt;
  logic is_rd, wr_pend;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [23:0] shift;
  logic [31:0] wdata, rd_word;
  logic [31:0] mem [2**ADDR_W];
`ifdef SPI_RESP_STATUS_EN
  logic [6:0] wr_cnt;
`endif
  assign {clk_s, css_s, mosi_s} = sync_q[SYNC_N-1];
  assign strobe = clk_d & ~clk_s & ~css_s;
  assign idx_nx = ADDR_W'({idx, mosi_s});
  assign rd_word = mem[idx_nx];
  // synchronize the SPI inputs; chip select resets inactive so no phantom frame starts
  always_ff @(posedge p_clk or negedge p_reset_n)
    if (!p_reset_n) begin
      sync_q <= {SYNC_N{10'h100}};
      clk_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], s_clk, s_css, s_mosi};
      clk_d <= clk_s;
    end
  // frame FSM: decode command, collect address, stream read data or gather write data
  always_ff @(posedge p_clk or negedge p_reset_n)
    if (!p_reset_n) begin
      state <= IDLE;
      cnt <= '0;
      is_rd <= 1'b0;
      idx <= '0;
      shift <= '0;
      wdata <= '0;
      wr_pend <= 1'b0;
      s_miso <= '0;
      cmd_err <= 1'b0;
`ifdef SPI_RESP_STATUS_EN
      wr_cnt <= '0;
`endif
    end else begin
      wr_pend <= 1'b0;
`ifdef SPI_RESP_STATUS_EN
      if (wr_pend) wr_cnt <= wr_cnt + 7'd1;
`endif
      if (css_s) begin
        state <= IDLE;
        cnt <= '0;
        s_miso <= '0;
      end else if (state == IDLE) begin
        state <= CMD;
      end else if (strobe) begin
        case (state)
          CMD: begin
            if (mosi_s == 8'h01 || mosi_s == 8'h02) begin
              state <= ADDR;
              is_rd <= (mosi_s == 8'h01);
            end
`ifdef SPI_RESP_STATUS_EN
            else if (mosi_s == 8'h05) begin
              state <= STAT;
              s_miso <= {cmd_err, wr_cnt};
            end
`endif
            else begin
              cmd_err <= 1'b1;
              state <= SKIP;
            end
          end
          ADDR: begin
            idx <= idx_nx;
            cnt <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
            if (cnt == 2'd2) begin
              state <= is_rd ? RDATA : WDATA;
              if (is_rd) begin
                shift <= rd_word[23:0];
                s_miso <= rd_word[31:24];
              end
            end
          end
          RDATA: begin
            cnt <= cnt + 2'd1;
            s_miso <= (cnt == 2'd3) ? 8'h00 : shift[23:16];
            shift <= {shift[15:0], 8'h00};
            if (cnt == 2'd3) state <= SKIP;
          end
          WDATA: begin
            wdata <= {wdata[23:0], mosi_s};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              wr_pend <= 1'b1;
              state <= SKIP;
            end
          end
          default: ;
        endcase
      end
    end
  // commit a completed write one cycle after its last data byte; memory is never reset
  always_ff @(posedge p_clk)
    if (wr_pend) mem[idx] <= wdata;
endmodule
